rv32_core_top: RTL and testbench

//  Single-cycle 32-bit RISC-V (RV32I subset) core: PC, instruction ROM, 32x32 register file,
//  ALU, branch unit and word-addressed data RAM. Top level of the processor.

---
 rtl/rv32_core_top.sv | 172 +++++++++++++++++
 tb/tb_rv32_core_top.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32_core_top.sv
// rv32_core_top: single-cycle RV32I-subset core with instruction ROM, 32x32 register file and word RAM.
// Optional MUL instruction is enabled by defining RV_MUL_EN.
module rv32_core_top #(
  parameter int unsigned IMEM_DEPTH = 64,
  parameter int unsigned DMEM_DEPTH = 64,
  parameter string       IMEM_FILE  = "program.mem",
  parameter logic [31:0] RESET_PC   = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] intr_result
);

  localparam int unsigned IW      = $clog2(IMEM_DEPTH);
  localparam int unsigned DW      = $clog2(DMEM_DEPTH);
  localparam logic [31:0] PC_MASK = 32'(4 * IMEM_DEPTH - 1);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  logic [31:0] pc, pc_next;
  logic [31:0] regs [32];
  logic [31:0] imem [IMEM_DEPTH];
  logic [31:0] dmem [DMEM_DEPTH];

  logic [31:0] instr;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] rs1_val, rs2_val;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] mem_addr, load_val, result;
  logic        rd_we, dmem_we, taken;

  assign instr  = imem[pc[IW+1:2]];
  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'h000};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  assign rs1_val  = (rs1 == 5'd0) ? 32'h0 : regs[rs1];
  assign rs2_val  = (rs2 == 5'd0) ? 32'h0 : regs[rs2];
  assign mem_addr = rs1_val + ((opcode == OP_SW) ? imm_s : imm_i);
  assign load_val = dmem[mem_addr[DW+1:2]];

  // Decode/execute; unsupported encodings fall through as NOP with a zero result
  always_comb begin
    result  = 32'h0;
    rd_we   = 1'b0;
    dmem_we = 1'b0;
    taken   = 1'b0;
    pc_next = pc + 32'd4;
    case (opcode)
      OP_R: begin
        rd_we = 1'b1;
        case ({funct7, funct3})
          {7'h00, 3'h0}: result = rs1_val + rs2_val;
          {7'h20, 3'h0}: result = rs1_val - rs2_val;
          {7'h00, 3'h1}: result = rs1_val << rs2_val[4:0];
          {7'h00, 3'h2}: result = {31'b0, $signed(rs1_val) < $signed(rs2_val)};
          {7'h00, 3'h3}: result = {31'b0, rs1_val < rs2_val};
          {7'h00, 3'h4}: result = rs1_val ^ rs2_val;
          {7'h00, 3'h5}: result = rs1_val >> rs2_val[4:0];
          {7'h20, 3'h5}: result = 32'($signed(rs1_val) >>> rs2_val[4:0]);
          {7'h00, 3'h6}: result = rs1_val | rs2_val;
          {7'h00, 3'h7}: result = rs1_val & rs2_val;
`ifdef RV_MUL_EN
          {7'h01, 3'h0}: result = rs1_val * rs2_val;
`endif
          default:       rd_we  = 1'b0;
        endcase
      end
      OP_I: begin
        rd_we = 1'b1;
        case (funct3)
          3'h0: result = rs1_val + imm_i;
          3'h2: result = {31'b0, $signed(rs1_val) < $signed(imm_i)};
          3'h3: result = {31'b0, rs1_val < imm_i};
          3'h4: result = rs1_val ^ imm_i;
          3'h6: result = rs1_val | imm_i;
          3'h7: result = rs1_val & imm_i;
          3'h1: begin
            if (funct7 == 7'h00) result = rs1_val << rs2;
            else                 rd_we  = 1'b0;
          end
          default: begin
            if (funct7 == 7'h00)      result = rs1_val >> rs2;
            else if (funct7 == 7'h20) result = 32'($signed(rs1_val) >>> rs2);
            else                      rd_we  = 1'b0;
          end
        endcase
      end
      OP_LW: begin
        if (funct3 == 3'h2) begin
          rd_we  = 1'b1;
          result = load_val;
        end
      end
      OP_SW: begin
        if (funct3 == 3'h2) begin
          dmem_we = 1'b1;
          result  = mem_addr;
        end
      end
      OP_BR: begin
        case (funct3)
          3'h0:    taken = (rs1_val == rs2_val);
          3'h1:    taken = (rs1_val != rs2_val);
          3'h4:    taken = ($signed(rs1_val) < $signed(rs2_val));
          3'h5:    taken = ($signed(rs1_val) >= $signed(rs2_val));
          default: taken = 1'b0;
        endcase
        result = {31'b0, taken};
        if (taken) pc_next = pc + imm_b;
      end
      OP_JAL: begin
        rd_we   = 1'b1;
        result  = pc + 32'd4;
        pc_next = pc + imm_j;
      end
      OP_JALR: begin
        if (funct3 == 3'h0) begin
          rd_we   = 1'b1;
          result  = pc + 32'd4;
          pc_next = (rs1_val + imm_i) & ~32'd1;
        end
      end
      OP_LUI: begin
        rd_we  = 1'b1;
        result = imm_u;
      end
      OP_AUIPC: begin
        rd_we  = 1'b1;
        result = pc + imm_u;
      end
      default: ;
    endcase
  end

  assign intr_result = reset ? result : 32'h0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc <= RESET_PC;
      for (int i = 0; i < 32; i++) regs[i] <= 32'h0;
    end else begin
      pc <= pc_next & PC_MASK;
      if (rd_we && rd != 5'd0) regs[rd] <= result;
    end
  end

  // Data RAM keeps its contents across reset
  always_ff @(posedge clk) begin
    if (reset && dmem_we) dmem[mem_addr[DW+1:2]] <= rs2_val;
  end

endmodule

// File: tb/tb_rv32_core_top.sv
// Bench for rv32_core_top: directed program from the ISA examples plus random programs
// checked cycle by cycle against an instruction-level reference model.
module tb_rv32_core_top;

  logic        clk;
  logic        reset;
  logic [31:0] intr_result;

  int total = 0;
  int bad   = 0;

  rv32_core_top #(
    .IMEM_DEPTH(64),
    .DMEM_DEPTH(64),
    .IMEM_FILE (""),
    .RESET_PC  (32'h0)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .intr_result(intr_result)
  );

  always #5 clk = ~clk;

  typedef enum logic [4:0] {
    I_ADD, I_SUB, I_AND, I_OR, I_XOR, I_SLL, I_SRL, I_SRA, I_SLT, I_SLTU,
    I_ADDI, I_ANDI, I_ORI, I_XORI, I_SLTI, I_SLTIU, I_SLLI, I_SRLI, I_SRAI,
    I_LW, I_SW, I_BEQ, I_BNE, I_BLT, I_BGE, I_JAL, I_JALR, I_LUI, I_AUIPC,
    I_MUL, I_BAD
  } op_e;

  typedef struct packed {
    op_e         op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } ins_t;

`ifdef RV_MUL_EN
  localparam logic [31:0] MULV = 32'hFFFF_FFF1;
`else
  localparam logic [31:0] MULV = 32'h0;
`endif

  ins_t        prog [64];
  logic [31:0] m_x   [32];
  logic [31:0] m_mem [64];
  logic [31:0] m_pc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic ins_t mk(input op_e op, input int rd, input int rs1, input int rs2, input int imm);
    ins_t i;
    i.op  = op;
    i.rd  = 5'(rd);
    i.rs1 = 5'(rs1);
    i.rs2 = 5'(rs2);
    i.imm = 32'(imm);
    return i;
  endfunction

  // Assembler: mnemonic record -> RV32 machine word
  function automatic logic [31:0] enc(input ins_t i);
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [31:0] k;
    k  = i.imm;
    f7 = 7'h00;
    f3 = 3'h0;
    case (i.op)
      I_SUB, I_SRA, I_SRAI:   f7 = 7'h20;
      I_MUL:                  f7 = 7'h01;
      default: ;
    endcase
    case (i.op)
      I_SLL, I_SLLI, I_BNE:            f3 = 3'h1;
      I_SLT, I_SLTI, I_LW, I_SW:       f3 = 3'h2;
      I_SLTU, I_SLTIU:                 f3 = 3'h3;
      I_XOR, I_XORI, I_BLT:            f3 = 3'h4;
      I_SRL, I_SRA, I_SRLI, I_SRAI, I_BGE: f3 = 3'h5;
      I_OR, I_ORI:                     f3 = 3'h6;
      I_AND, I_ANDI:                   f3 = 3'h7;
      default: ;
    endcase
    case (i.op)
      I_ADD, I_SUB, I_AND, I_OR, I_XOR, I_SLL, I_SRL, I_SRA, I_SLT, I_SLTU, I_MUL:
        return {f7, i.rs2, i.rs1, f3, i.rd, 7'b0110011};
      I_SLLI, I_SRLI, I_SRAI:
        return {f7, k[4:0], i.rs1, f3, i.rd, 7'b0010011};
      I_ADDI, I_ANDI, I_ORI, I_XORI, I_SLTI, I_SLTIU:
        return {k[11:0], i.rs1, f3, i.rd, 7'b0010011};
      I_LW:    return {k[11:0], i.rs1, f3, i.rd, 7'b0000011};
      I_JALR:  return {k[11:0], i.rs1, 3'h0, i.rd, 7'b1100111};
      I_SW:    return {k[11:5], i.rs2, i.rs1, f3, k[4:0], 7'b0100011};
      I_BEQ, I_BNE, I_BLT, I_BGE:
        return {k[12], k[10:5], i.rs2, i.rs1, f3, k[4:1], k[11], 7'b1100011};
      I_JAL:   return {k[20], k[10:1], k[11], k[19:12], i.rd, 7'b1101111};
      I_LUI:   return {k[31:12], i.rd, 7'b0110111};
      I_AUIPC: return {k[31:12], i.rd, 7'b0010111};
      default: return {k[24:0], 7'b0001011};
    endcase
  endfunction

  function automatic ins_t rand_ins();
    ins_t        i;
    logic [31:0] r;
    r     = $urandom;
    i.op  = op_e'(5'($urandom_range(0, 30)));
    i.rd  = 5'($urandom_range(0, 7));
    i.rs1 = 5'($urandom_range(0, 7));
    i.rs2 = 5'($urandom_range(0, 7));
    case (i.op)
      I_SLLI, I_SRLI, I_SRAI:           i.imm = 32'(r[4:0]);
      I_BEQ, I_BNE, I_BLT, I_BGE, I_JAL: i.imm = {{26{r[5]}}, r[5:2], 2'b00};
      I_LUI, I_AUIPC:                   i.imm = {r[31:12], 12'h000};
      I_BAD:                            i.imm = r;
      default:                          i.imm = {{20{r[11]}}, r[11:0]};
    endcase
    return i;
  endfunction

  // Reference ISS: executes one mnemonic record, returns the writeback value
  task automatic model_step(output logic [31:0] res);
    ins_t        c;
    logic [31:0] a, b, npc, addr;
    logic        wr;
    c    = prog[(m_pc >> 2) % 64];
    a    = m_x[c.rs1];
    b    = m_x[c.rs2];
    npc  = m_pc + 4;
    addr = a + c.imm;
    wr   = 1'b1;
    res  = 32'h0;
    case (c.op)
      I_ADD:   res = a + b;
      I_SUB:   res = a - b;
      I_AND:   res = a & b;
      I_OR:    res = a | b;
      I_XOR:   res = a ^ b;
      I_SLL:   res = a << (b % 32);
      I_SRL:   res = a >> (b % 32);
      I_SRA:   res = $signed(a) >>> (b % 32);
      I_SLT:   res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      I_SLTU:  res = (a < b) ? 32'd1 : 32'd0;
      I_ADDI:  res = a + c.imm;
      I_ANDI:  res = a & c.imm;
      I_ORI:   res = a | c.imm;
      I_XORI:  res = a ^ c.imm;
      I_SLTI:  res = ($signed(a) < $signed(c.imm)) ? 32'd1 : 32'd0;
      I_SLTIU: res = (a < c.imm) ? 32'd1 : 32'd0;
      I_SLLI:  res = a << c.imm;
      I_SRLI:  res = a >> c.imm;
      I_SRAI:  res = $signed(a) >>> c.imm;
      I_LW:    res = m_mem[(addr >> 2) % 64];
      I_SW: begin
        wr = 1'b0;
        m_mem[(addr >> 2) % 64] = b;
        res = addr;
      end
      I_BEQ, I_BNE, I_BLT, I_BGE: begin
        wr = 1'b0;
        if ((c.op == I_BEQ && a == b) || (c.op == I_BNE && a != b) ||
            (c.op == I_BLT && $signed(a) < $signed(b)) ||
            (c.op == I_BGE && $signed(a) >= $signed(b))) begin
          res = 32'd1;
          npc = m_pc + c.imm;
        end
      end
      I_JAL: begin
        res = m_pc + 4;
        npc = m_pc + c.imm;
      end
      I_JALR: begin
        res = m_pc + 4;
        npc = addr & 32'hFFFF_FFFE;
      end
      I_LUI:   res = c.imm;
      I_AUIPC: res = m_pc + c.imm;
`ifdef RV_MUL_EN
      I_MUL:   res = a * b;
`endif
      default: wr = 1'b0;
    endcase
    if (wr && c.rd != 5'd0) m_x[c.rd] = res;
    m_pc = npc % 256;
  endtask

  task automatic load_prog();
    for (int k = 0; k < 64; k++) dut.imem[k] = enc(prog[k]);
  endtask

  logic [31:0] dir_exp [20];
  logic [31:0] exp_v;

  initial begin
    clk   = 1'b0;
    reset = 1'b0;

    for (int k = 0; k < 64; k++) begin
      prog[k]     = mk(I_ADDI, 0, 0, 0, 0);
      dut.dmem[k] = 32'h0;
    end
    prog[0]  = mk(I_ADDI, 1, 0, 0, 5);
    prog[1]  = mk(I_ADDI, 2, 0, 0, -3);
    prog[2]  = mk(I_ADD,  3, 1, 2, 0);
    prog[3]  = mk(I_SW,   0, 0, 3, 8);
    prog[4]  = mk(I_LW,   4, 0, 0, 8);
    prog[5]  = mk(I_SUB,  5, 0, 4, 0);
    prog[6]  = mk(I_BEQ,  0, 1, 1, 8);
    prog[7]  = mk(I_ADDI, 9, 0, 0, 99);
    prog[8]  = mk(I_ADDI, 0, 0, 0, 7);
    prog[9]  = mk(I_ADD,  7, 0, 0, 0);
    prog[10] = mk(I_MUL,  8, 1, 2, 0);
    prog[11] = mk(I_ADD, 10, 8, 0, 0);
    prog[12] = mk(I_ADD, 11, 9, 0, 0);
    prog[13] = mk(I_BNE,  0, 1, 1, 8);
    prog[14] = mk(I_JAL,  6, 0, 0, 8);
    prog[15] = mk(I_ADDI,13, 0, 0, 1);
    prog[16] = mk(I_ADD, 12, 6, 0, 0);
    prog[17] = mk(I_JAL,  6, 0, 0, -16);
    load_prog();

    dir_exp = '{32'd5, 32'hFFFF_FFFD, 32'd2, 32'd8, 32'd2, 32'hFFFF_FFFE, 32'd1, 32'd7,
                32'd0, MULV, MULV, 32'd0, 32'd0, 32'd60, 32'd60, 32'd72,
                32'd0, 32'd60, 32'd60, 32'd72};

    // Long reset: nothing executes
    repeat (20) begin
      @(negedge clk);
      #1 check("rst_hold", intr_result, 32'h0);
    end

    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 20; k++) begin
      #1 check($sformatf("dir%0d", k), intr_result, dir_exp[k]);
      @(negedge clk);
    end

    // Mid-run async reset; slot 0 now reads x5, which must have been cleared
    #3 reset = 1'b0;
    #1 check("rst_pulse", intr_result, 32'h0);
    dut.imem[0] = enc(mk(I_ADD, 14, 5, 0, 0));
    @(negedge clk);
    #1 check("rst_pulse2", intr_result, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    #1 check("rst_x5_clear", intr_result, 32'h0);
    @(negedge clk);
    #1 check("rst_restart", intr_result, 32'hFFFF_FFFD);

    for (int p = 0; p < 4; p++) begin
      @(negedge clk);
      reset = 1'b0;
      for (int k = 0; k < 64; k++) begin
        prog[k]     = rand_ins();
        m_mem[k]    = 32'h0;
        dut.dmem[k] = 32'h0;
      end
      for (int k = 0; k < 32; k++) m_x[k] = 32'h0;
      m_pc = 32'h0;
      load_prog();
      repeat (2) @(negedge clk);
      reset = 1'b1;
      for (int k = 0; k < 250; k++) begin
        #1;
        model_step(exp_v);
        check($sformatf("rand p%0d c%0d", p, k), intr_result, exp_v);
        @(negedge clk);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
